// File: rtl/pixel_rx_if.sv
// Port bundle for pixel_rx: serial LED-strip input plus decoded pixel/frame outputs.
// Handshake: pix_valid, frame_done and err are single-cycle strobes with no back-pressure;
// pix_data/pix_index are meaningful while pix_valid=1 and hold until the next pix_valid.
interface pixel_rx_if;
  logic        din;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic [7:0]  pix_index;
  logic        frame_done;
  logic [7:0]  pix_count;
  logic        err;
  logic        overflow;
  logic [1:0]  state_dbg;

  modport master (
    output din,
    input  pix_valid, pix_data, pix_index, frame_done, pix_count, err, overflow, state_dbg
  );

  modport slave (
    input  din,
    output pix_valid, pix_data, pix_index, frame_done, pix_count, err, overflow, state_dbg
  );
endinterface

// File: rtl/pixel_rx.sv
// Pulse-width decoder for a WS281x-style LED-strip line: recovers 24-bit pixels
// (LSB first) per frame, with frame-gap detection, glitch filtering and error reporting.
module pixel_rx #(
  parameter int THRESH       = 8,
  parameter int MIN_HIGH     = 2,
  parameter int MAX_HIGH     = 31,
  parameter int RESET_CYCLES = 500,
  parameter int MAX_PIX      = 60
) (
  input  logic       clk,
  input  logic       rst,
  pixel_rx_if.slave  bus
);
  localparam int HI_W = $clog2(MAX_HIGH + 2);
  localparam int LO_W = $clog2(RESET_CYCLES + 1);

  localparam logic [HI_W-1:0] HI_ONE = HI_W'(1);
  localparam logic [HI_W-1:0] HI_SAT = HI_W'(MAX_HIGH + 1);
  localparam logic [HI_W-1:0] HI_MIN = HI_W'(MIN_HIGH);
  localparam logic [HI_W-1:0] HI_THR = HI_W'(THRESH);
  localparam logic [LO_W-1:0] LO_ONE = LO_W'(1);
  localparam logic [LO_W-1:0] LO_END = LO_W'(RESET_CYCLES);
  localparam logic [7:0]      SLOT_MAX = 8'(MAX_PIX);

  localparam logic [1:0] ST_SYNC = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_LOW  = 2'd3;

  logic            din_m_q, din_m_d;
  logic            din_s_q, din_s_d;
  logic [1:0]      state_q, state_d;
  logic            from_low_q, from_low_d;
  logic [HI_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [LO_W-1:0] lo_cnt_q, lo_cnt_d;
  logic [4:0]      bit_cnt_q, bit_cnt_d;
  logic [23:0]     word_q, word_d;
  logic [7:0]      slot_q, slot_d;
  logic            pix_valid_q, pix_valid_d;
  logic [23:0]     pix_data_q, pix_data_d;
  logic [7:0]      pix_index_q, pix_index_d;
  logic            frame_done_q, frame_done_d;
  logic [7:0]      pix_count_q, pix_count_d;
  logic            err_q, err_d;
  logic            overflow_q, overflow_d;

  logic [HI_W-1:0] hi_inc;
  logic [LO_W-1:0] lo_inc;
  logic            bit_val;

  always_comb begin
    din_m_d      = bus.din;
    din_s_d      = din_m_q;
    state_d      = state_q;
    from_low_d   = from_low_q;
    hi_cnt_d     = hi_cnt_q;
    lo_cnt_d     = lo_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    word_d       = word_q;
    slot_d       = slot_q;
    pix_valid_d  = 1'b0;
    pix_data_d   = pix_data_q;
    pix_index_d  = pix_index_q;
    frame_done_d = 1'b0;
    pix_count_d  = pix_count_q;
    err_d        = 1'b0;
    overflow_d   = overflow_q;

    hi_inc  = (hi_cnt_q == HI_SAT) ? HI_SAT : hi_cnt_q + HI_ONE;
    lo_inc  = (lo_cnt_q == LO_END) ? LO_END : lo_cnt_q + LO_ONE;
    bit_val = (hi_cnt_q >= HI_THR);

    case (state_q)
      ST_SYNC: begin
        // Pulses here are ignored; any high restarts the gap measurement.
        if (din_s_q) begin
          lo_cnt_d = '0;
        end else if (lo_inc == LO_END) begin
          lo_cnt_d = '0;
          state_d  = ST_IDLE;
        end else begin
          lo_cnt_d = lo_inc;
        end
      end

      ST_IDLE: begin
        if (din_s_q) begin
          state_d    = ST_HIGH;
          hi_cnt_d   = HI_ONE;
          from_low_d = 1'b0;
        end
      end

      ST_LOW: begin
        if (din_s_q) begin
          state_d    = ST_HIGH;
          hi_cnt_d   = HI_ONE;
          from_low_d = 1'b1;
        end else begin
          lo_cnt_d = lo_inc;
          if (lo_inc == LO_END) begin
            frame_done_d = 1'b1;
            pix_count_d  = slot_q;
            err_d        = (bit_cnt_q != 5'd0);
            bit_cnt_d    = 5'd0;
            word_d       = '0;
            slot_d       = 8'd0;
            lo_cnt_d     = '0;
            state_d      = ST_IDLE;
          end
        end
      end

      ST_HIGH: begin
        if (din_s_q) begin
          hi_cnt_d = hi_inc;
          // Over-long high: the frame is unusable, so drop it and resynchronise.
          if (hi_inc == HI_SAT) begin
            err_d     = 1'b1;
            bit_cnt_d = 5'd0;
            word_d    = '0;
            slot_d    = 8'd0;
            lo_cnt_d  = '0;
            state_d   = ST_SYNC;
          end
        end else if (hi_cnt_q < HI_MIN) begin
          state_d  = from_low_q ? ST_LOW : ST_IDLE;
          lo_cnt_d = LO_ONE;
        end else begin
          state_d  = ST_LOW;
          lo_cnt_d = LO_ONE;
          if (bit_cnt_q == 5'd23) begin
            bit_cnt_d = 5'd0;
            word_d    = '0;
            if (slot_q >= SLOT_MAX) begin
              overflow_d = 1'b1;
            end else begin
              pix_valid_d = 1'b1;
              pix_data_d  = {bit_val, word_q[22:0]};
              pix_index_d = slot_q;
              slot_d      = slot_q + 8'd1;
            end
          end else begin
            word_d    = word_q | (24'(bit_val) << bit_cnt_q);
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end

      default: state_d = ST_SYNC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_m_q      <= 1'b0;
      din_s_q      <= 1'b0;
      state_q      <= ST_SYNC;
      from_low_q   <= 1'b0;
      hi_cnt_q     <= '0;
      lo_cnt_q     <= '0;
      bit_cnt_q    <= 5'd0;
      word_q       <= '0;
      slot_q       <= 8'd0;
      pix_valid_q  <= 1'b0;
      pix_data_q   <= '0;
      pix_index_q  <= 8'd0;
      frame_done_q <= 1'b0;
      pix_count_q  <= 8'd0;
      err_q        <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      din_m_q      <= din_m_d;
      din_s_q      <= din_s_d;
      state_q      <= state_d;
      from_low_q   <= from_low_d;
      hi_cnt_q     <= hi_cnt_d;
      lo_cnt_q     <= lo_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      word_q       <= word_d;
      slot_q       <= slot_d;
      pix_valid_q  <= pix_valid_d;
      pix_data_q   <= pix_data_d;
      pix_index_q  <= pix_index_d;
      frame_done_q <= frame_done_d;
      pix_count_q  <= pix_count_d;
      err_q        <= err_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.pix_valid  = pix_valid_q;
  assign bus.pix_data   = pix_data_q;
  assign bus.pix_index  = pix_index_q;
  assign bus.frame_done = frame_done_q;
  assign bus.pix_count  = pix_count_q;
  assign bus.err        = err_q;
  assign bus.overflow   = overflow_q;
  assign bus.state_dbg  = state_q;

  a_pix_valid_single: assert property (@(posedge clk) disable iff (rst) pix_valid_q |=> !pix_valid_q);
  a_frame_done_single: assert property (@(posedge clk) disable iff (rst) frame_done_q |=> !frame_done_q);
  a_err_single: assert property (@(posedge clk) disable iff (rst) err_q |=> !err_q);
endmodule
